img_buf_ctrl: RTL and testbench
===============================

IMG_BUF_CTRL -- requirements
Module: img_buf_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 24, meaning buffer capacity in bytes; it is a multiple of 3 and at least 7.
REQ-002 The block SHALL have parameter AW, default 18, meaning buffer address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle pulse that launches a job.
REQ-006 The block SHALL have port len_beats, input, 16 bits: number of 3-byte beats to load, sampled on start.
REQ-007 The block SHALL have port stride, input, 3 bits: window step in bytes, sampled on start.
REQ-008 The block SHALL have ports s_valid (input, 1), s_ready (output, 1), s_data (input, 24) and s_last (input, 1): the pixel input stream, with the first byte in s_data[23:16].
REQ-009 The block SHALL have ports buf_ce (output, 1), buf_we (output, 1), buf_addr (output, AW) and buf_d (output, 24): the buffer control outputs.
REQ-010 The block SHALL have port buf_q, input, 56 bits: combinational 7-byte read window at buf_addr.
REQ-011 The block SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_data (output, 56): the window output stream.
REQ-012 The block SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and err (output, 1, sticky until next start).

Function
REQ-013 FSM states SHALL be IDLE, FILL, DRAIN and FLUSH.
REQ-014 IDLE, start=1: latch len_beats and stride; a stride of 0 SHALL be treated as 1; clear err.
REQ-015 If the latched len_beats is 0, the next state SHALL be FLUSH; otherwise it SHALL be FILL.
REQ-016 If 3*len_beats > DEPTH, the beat count SHALL be clamped to DEPTH/3 and err set.
REQ-017 In FILL, s_ready SHALL be 1 and every s_valid&&s_ready beat SHALL assert buf_ce=1 and buf_we=1 that cycle, with buf_addr=wptr and buf_d=s_data.
REQ-018 After each FILL beat, wptr SHALL advance by 3.
REQ-019 Leaving FILL SHALL record nbytes = wptr after the last accepted beat.
REQ-020 FILL SHALL exit to DRAIN when the beat count is reached.
REQ-021 s_last on an earlier beat SHALL set err and exit FILL to DRAIN.
REQ-022 s_last absent on the final beat SHALL be ignored, with no error.
REQ-023 In DRAIN, with rptr starting at 0: if rptr+7 <= nbytes and the output register is empty or being consumed, the block SHALL drive buf_ce=1, buf_we=0 and buf_addr=rptr, capture buf_q into m_data on the same edge, set m_valid, and advance rptr by stride.
REQ-024 The DRAIN read path SHALL have a latency of 1 cycle from read to m_valid.
REQ-025 With m_ready held high, the output SHALL sustain 1 window per cycle.
REQ-026 DRAIN SHALL exit to FLUSH when rptr+7 > nbytes, which includes the case nbytes < 7 (zero windows).
REQ-027 FLUSH SHALL wait until m_valid is 0 or is consumed, then pulse done for 1 cycle and return to IDLE.
REQ-028 m_valid/m_data SHALL remain stable until m_ready is high.
REQ-029 When idle, buf_ce, buf_we and s_ready SHALL be 0.
REQ-030 buf_ce and buf_we SHALL never both assert for read and write in the same cycle.
REQ-031 start while busy SHALL be ignored.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 Address arithmetic SHALL be AW bits wide and SHALL never wrap, since it is bounded by DEPTH.

Reset
REQ-034 While rstn=0, the state SHALL be IDLE and wptr, rptr, nbytes, m_data, m_valid, s_ready, buf_ce, buf_we, buf_addr, buf_d, busy, done and err SHALL all be 0.
REQ-035 rstn deasserted mid-job SHALL abort the job and discard its data, with no done pulse.

Configuration
REQ-036 Macro IMG_BUF_CTRL_PERF_EN, when defined, SHALL add output perf_cycles (32 bits).
REQ-037 perf_cycles SHALL clear on an accepted start, increment each busy cycle, hold after done, and saturate at all-ones.
REQ-038 When IMG_BUF_CTRL_PERF_EN is undefined, the port and counter SHALL be absent and the rest of the behaviour SHALL be identical.

Structure
REQ-039 A shared package SHALL hold the FSM state enum, the constants WIN_BYTES=7 and BEAT_BYTES=3, and the width parameters.
REQ-040 The output register and its valid/ready handshake SHALL be one sub-module, img_win_skid.
REQ-041 The FSM and pointers SHALL live in the top module.

Verification
REQ-042 Nominal: start with len_beats=8 and stride=1, feed 24 incrementing bytes 0..23 with m_ready=1 -> 18 windows, the first {0..6}, the last {17..23}; done pulses once.
REQ-043 Stride: len_beats=8, stride=3 -> 6 windows starting at bytes 0,3,6,9,12,15.
REQ-044 Stride 0: len_beats=8, stride=0 -> same result as stride=1.
REQ-045 Backpressure: toggle m_ready randomly -> no window lost or duplicated, and m_data stays stable while m_valid=1 and m_ready=0.
REQ-046 Early s_last on beat 2 with len_beats=8 -> err=1, nbytes=6, 0 windows, done pulses.
REQ-047 Oversize and reset: len_beats=20 -> clamp to 8 beats, err=1; separately, assert rstn low mid-DRAIN -> all outputs 0, IDLE, no done pulse.

Source files
------------

// File: rtl/img_buf_ctrl_pkg.sv
// Shared definitions for the image buffer controller: FSM states,
// byte-geometry constants and stream widths.
package img_buf_ctrl_pkg;

    localparam int unsigned WIN_BYTES  = 7;
    localparam int unsigned BEAT_BYTES = 3;

    localparam int unsigned LEN_W    = 16;
    localparam int unsigned STRIDE_W = 3;
    localparam int unsigned BEAT_W   = 8 * BEAT_BYTES;
    localparam int unsigned WIN_W    = 8 * WIN_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/img_win_skid.sv
// Window output register with valid/ready handshake. The data register
// loads whenever it is empty or its current contents are being consumed,
// so a ready-high sink sees one window per cycle.
module img_win_skid
    import img_buf_ctrl_pkg::*;
#(
    parameter int unsigned W = WIN_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_can_load
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Capture a new window or retire the held one when the sink takes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_can_load = !r_valid || i_ready;

endmodule

// File: rtl/img_buf_ctrl.sv
// Image buffer controller: loads a job of 3-byte beats into an external
// buffer, then reads back overlapping 7-byte windows at a programmable
// stride. Optional cycle counter output enabled by IMG_BUF_CTRL_PERF_EN.
module img_buf_ctrl
    import img_buf_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 24,
    parameter int unsigned AW    = 18
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [LEN_W-1:0]    len_beats,
    input  logic [STRIDE_W-1:0] stride,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BEAT_W-1:0]   s_data,
    input  logic                s_last,
    output logic                buf_ce,
    output logic                buf_we,
    output logic [AW-1:0]       buf_addr,
    output logic [BEAT_W-1:0]   buf_d,
    input  logic [WIN_W-1:0]    buf_q,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [WIN_W-1:0]    m_data,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef IMG_BUF_CTRL_PERF_EN
    ,
    output logic [31:0]         perf_cycles
`endif
);

    localparam logic [LEN_W-1:0] MAX_BEATS = LEN_W'(DEPTH / BEAT_BYTES);
    localparam logic [AW-1:0]    AW_BEAT   = AW'(BEAT_BYTES);
    localparam logic [AW-1:0]    AW_WIN    = AW'(WIN_BYTES);

    state_t              r_state;
    logic [LEN_W-1:0]    r_tgt;
    logic [LEN_W-1:0]    r_cnt;
    logic [STRIDE_W-1:0] r_stride;
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [AW-1:0]       r_nbytes;
    logic                r_err;
    logic                r_done;

    logic [LEN_W+1:0]    w_len_x3;
    logic                w_oversize;
    logic [LEN_W-1:0]    w_len_eff;
    logic                w_start_acc;
    logic                w_beat;
    logic [LEN_W-1:0]    w_cnt_next;
    logic [AW-1:0]       w_wptr_next;
    logic                w_win_fits;
    logic                w_can_load;
    logic                w_rd;
    logic                w_flush_ok;

    assign w_len_x3    = {2'b00, len_beats} + {1'b0, len_beats, 1'b0};
    assign w_oversize  = w_len_x3 > (LEN_W + 2)'(DEPTH);
    assign w_len_eff   = w_oversize ? MAX_BEATS : len_beats;
    assign w_start_acc = start && (r_state == ST_IDLE);
    assign w_beat      = (r_state == ST_FILL) && s_valid;
    assign w_cnt_next  = r_cnt + LEN_W'(1);
    assign w_wptr_next = r_wptr + AW_BEAT;
    assign w_win_fits  = (r_rptr + AW_WIN) <= r_nbytes;
    assign w_rd        = (r_state == ST_DRAIN) && w_win_fits && w_can_load;
    assign w_flush_ok  = !m_valid || m_ready;

    // Job sequencing: latch parameters, count beats in, walk windows out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_tgt    <= '0;
            r_cnt    <= '0;
            r_stride <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_nbytes <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_tgt    <= w_len_eff;
                        r_cnt    <= '0;
                        r_stride <= (stride == '0) ? STRIDE_W'(1) : stride;
                        r_err    <= w_oversize;
                        r_wptr   <= '0;
                        r_rptr   <= '0;
                        r_nbytes <= '0;
                        r_state  <= (len_beats == '0) ? ST_FLUSH : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_beat) begin
                        r_wptr <= w_wptr_next;
                        r_cnt  <= w_cnt_next;
                        if (w_cnt_next == r_tgt) begin
                            r_nbytes <= w_wptr_next;
                            r_state  <= ST_DRAIN;
                        end else if (s_last) begin
                            r_err    <= 1'b1;
                            r_nbytes <= w_wptr_next;
                            r_state  <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_rd) begin
                        r_rptr <= r_rptr + AW'(r_stride);
                    end else if (!w_win_fits) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_flush_ok) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Buffer port: writes in FILL, reads in DRAIN, quiet otherwise.
    always_comb begin
        buf_ce   = w_beat || w_rd;
        buf_we   = w_beat;
        buf_addr = '0;
        buf_d    = '0;
        if (r_state == ST_FILL) begin
            buf_addr = r_wptr;
            buf_d    = s_data;
        end else if (r_state == ST_DRAIN) begin
            buf_addr = r_rptr;
        end
    end

    assign s_ready = (r_state == ST_FILL);
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign err     = r_err;

    img_win_skid #(
        .W (WIN_W)
    ) u_skid (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_rd),
        .i_data     (buf_q),
        .i_ready    (m_ready),
        .o_valid    (m_valid),
        .o_data     (m_data),
        .o_can_load (w_can_load)
    );

`ifdef IMG_BUF_CTRL_PERF_EN
    logic [31:0] r_perf;

    // Busy-cycle counter: cleared by an accepted start, saturating.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf <= '0;
        end else if (w_start_acc) begin
            r_perf <= '0;
        end else if (busy && (r_perf != '1)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_img_buf_ctrl.sv
// Self-checking bench for img_buf_ctrl: external buffer model, random
// stream/backpressure, and a window-list reference model per job.
module tb_img_buf_ctrl;

    localparam int DEPTH = 24;
    localparam int AW    = 18;
    localparam int MEMSZ = 64;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   len_beats = '0;
    logic [2:0]    stride = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [23:0]   s_data = '0;
    logic          s_last = 1'b0;
    logic          buf_ce;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [23:0]   buf_d;
    logic [55:0]   buf_q;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [55:0]   m_data;
    logic          busy;
    logic          done;
    logic          err;

    img_buf_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .len_beats(len_beats),
        .stride(stride), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .buf_ce(buf_ce), .buf_we(buf_we),
        .buf_addr(buf_addr), .buf_d(buf_d), .buf_q(buf_q),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // External buffer: 3-byte writes, combinational 7-byte read window.
    logic [7:0] mem [0:MEMSZ-1];

    always @(posedge clk) begin
        if (buf_ce && buf_we) begin
            for (int i = 0; i < 3; i++) begin
                if (int'(buf_addr) + i < MEMSZ)
                    mem[int'(buf_addr) + i] <= buf_d[23 - 8*i -: 8];
            end
        end
    end

    always_comb begin
        int idx;
        idx   = 0;
        buf_q = '0;
        for (int i = 0; i < 7; i++) begin
            idx = int'(buf_addr) + i;
            buf_q[55 - 8*i -: 8] = (idx < MEMSZ) ? mem[idx] : 8'hEE;
        end
    end

    // Reference state
    logic [7:0]  src [0:95];
    logic [55:0] exp_q [$];
    int          n_offer = 0;
    int          last_at = -1;
    int          beat_idx = 0;
    int          win_cnt = 0;
    int          done_cnt = 0;
    int          rmode = 1;
    bit          feeding = 1'b0;
    bit          mon_en = 1'b1;
    logic [55:0] first_win = '0;
    logic [55:0] last_win = '0;

    // Stream source: random gaps; a beat is accepted at the edge following
    // a negedge where both valid and ready were high.
    initial begin
        bit pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) beat_idx++;
            if (feeding && beat_idx < n_offer) begin
                s_valid = ($urandom_range(3) != 0);
                s_data  = {src[3*beat_idx], src[3*beat_idx+1], src[3*beat_idx+2]};
                s_last  = (beat_idx == last_at);
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            pend = s_valid && s_ready && rstn;
        end
    end

    // Sink and compare: every consumed window is checked against the model.
    initial begin
        bit          stalled;
        logic [55:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            case (rmode)
                0:       m_ready = ($urandom_range(1) != 0);
                1:       m_ready = 1'b1;
                default: m_ready = 1'b0;
            endcase
            if (!rstn || !mon_en) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    chk("hold_stable", 64'({m_valid, m_data}), 64'({1'b1, held}));
                if (!busy)
                    chk("idle_quiet", 64'({buf_ce, buf_we, s_ready}), 64'(0));
                if (m_valid && m_ready) begin
                    if (win_cnt == 0) first_win = m_data;
                    last_win = m_data;
                    win_cnt++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL extra_window: got %0h want none", m_data);
                    end else begin
                        chk("window", 64'(m_data), 64'(exp_q.pop_front()));
                    end
                end
                stalled = m_valid && !m_ready;
                held    = m_data;
            end
            if (rstn && done) done_cnt++;
        end
    end

    task automatic run_job(input int len, input int st, input int last_i,
                           input int rm, input string tag);
        int          eff, beats, nb, s, n_exp, cyc;
        logic        err_exp;
        logic [55:0] w;
        eff     = (len > DEPTH/3) ? DEPTH/3 : len;
        err_exp = (len > DEPTH/3);
        beats   = eff;
        if (last_i >= 0 && last_i < eff - 1) begin
            beats   = last_i + 1;
            err_exp = 1'b1;
        end
        nb = 3 * beats;
        s  = (st == 0) ? 1 : st;
        exp_q.delete();
        for (int r = 0; r + 7 <= nb; r += s) begin
            for (int k = 0; k < 7; k++) w[55 - 8*k -: 8] = src[r + k];
            exp_q.push_back(w);
        end
        n_exp    = exp_q.size();
        n_offer  = (len < 32) ? len : 32;
        last_at  = last_i;
        rmode    = rm;
        win_cnt  = 0;
        done_cnt = 0;
        beat_idx = 0;
        @(negedge clk);
        len_beats = 16'(len);
        stride    = 3'(st);
        start     = 1'b1;
        feeding   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (len >= 4) begin
            // start while busy must be ignored
            @(negedge clk);
            len_beats = 16'd1;
            stride    = 3'd5;
            start     = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt > 0), 64'(1));
        feeding = 1'b0;
        repeat (4) @(negedge clk);
        chk({tag, "_done_once"}, 64'(done_cnt), 64'(1));
        chk({tag, "_windows"},   64'(win_cnt), 64'(n_exp));
        chk({tag, "_beats"},     64'(beat_idx), 64'(beats));
        chk({tag, "_err"},       64'(err), 64'(err_exp));
        chk({tag, "_busy"},      64'(busy), 64'(0));
        chk({tag, "_leftover"},  64'(exp_q.size()), 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"},  64'({m_valid, s_ready, buf_ce, buf_we, busy, done, err}), 64'(0));
        chk({tag, "_bus"},  64'({buf_addr, buf_d}), 64'(0));
        chk({tag, "_data"}, 64'(m_data), 64'(0));
    endtask

    initial begin
        int cyc;
        int ln, st, la, rm;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 96; i++) src[i] = 8'(i);

        // Nominal; s_last on the final beat carries no error
        run_job(8, 1, 7, 1, "nom");
        chk("nom_count", 64'(win_cnt), 64'(18));
        chk("nom_first", 64'(first_win), 64'(56'h00010203040506));
        chk("nom_last",  64'(last_win),  64'(56'h11121314151617));

        run_job(8, 3, -1, 1, "str3");
        chk("str3_count", 64'(win_cnt), 64'(6));
        chk("str3_last",  64'(last_win), 64'(56'h0f101112131415));

        run_job(8, 0, -1, 1, "str0");
        chk("str0_count", 64'(win_cnt), 64'(18));

        for (int i = 0; i < 96; i++) src[i] = 8'($urandom);
        run_job(8, 1, -1, 0, "bp");
        run_job(8, 2, -1, 0, "bp2");

        run_job(8, 1, 1, 0, "early");
        chk("early_count", 64'(win_cnt), 64'(0));
        chk("early_beats", 64'(beat_idx), 64'(2));
        chk("early_err",   64'(err), 64'(1));

        run_job(20, 1, -1, 1, "over");
        chk("over_beats", 64'(beat_idx), 64'(8));
        chk("over_err",   64'(err), 64'(1));

        run_job(0, 2, -1, 1, "zero");
        chk("zero_err", 64'(err), 64'(0));

        for (int j = 0; j < 12; j++) begin
            for (int i = 0; i < 96; i++) src[i] = 8'($urandom);
            ln = $urandom_range(0, 10);
            st = $urandom_range(0, 7);
            la = ($urandom_range(3) == 0) ? $urandom_range(0, 9) : -1;
            rm = $urandom_range(0, 1);
            run_job(ln, st, la, rm, "rnd");
        end

        // Reset while DRAIN is stalled by a non-ready sink
        for (int i = 0; i < 96; i++) src[i] = 8'(i);
        rmode    = 2;
        n_offer  = 8;
        last_at  = -1;
        beat_idx = 0;
        done_cnt = 0;
        exp_q.delete();
        @(negedge clk);
        len_beats = 16'd8;
        stride    = 3'd1;
        start     = 1'b1;
        feeding   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (beat_idx < 8 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        chk("abort_in_drain", 64'({busy, m_valid, s_ready}), 64'(3'b110));
        rstn = 1'b0;
        @(negedge clk);
        chk_all_zero("abort_rst");
        @(negedge clk);
        feeding = 1'b0;
        rstn    = 1'b1;
        rmode   = 1;
        repeat (10) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(0));
        chk("abort_idle",    64'({busy, m_valid}), 64'(0));

        run_job(8, 2, -1, 1, "post");
        chk("post_count", 64'(win_cnt), 64'(9));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
